// File: rtl/bcd_rtc.sv
// BCD real-time-clock core: prescaled seconds through year/weekday/leap phase,
// a field write port, and an atomic snapshot that is the only thing rd_data sees.
`timescale 1ns/1ps
module bcd_rtc #(
  parameter int TICK_DIV    = 32768,
  parameter bit HAS_WEEKDAY = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce_tick,
  input  logic       wr_en,
  input  logic [2:0] wr_sel,
  input  logic [7:0] wr_data,
  input  logic       latch,
  input  logic [2:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       halted
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  // Low digit 9 carries into the tens digit; any other digit (A-F too) just
  // increments, so F wraps to 0 with no carry.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [5:0] days_in_month(input logic [4:0] mon, input logic [1:0] lp);
    case (mon)
      5'h02:                      return (lp == 2'd0) ? 6'h29 : 6'h28;
      5'h04, 5'h06, 5'h09, 5'h11: return 6'h30;
      default:                    return 6'h31;
    endcase
  endfunction

  logic [PW-1:0] presc, nxt_presc;
  logic [6:0]    sec_r, min_r, nxt_sec, nxt_min;
  logic [5:0]    hour_r, day_r, nxt_hour, nxt_day;
  logic [4:0]    month_r, nxt_month;
  logic [7:0]    year_r, nxt_year;
  logic [2:0]    wday_r, nxt_wday;
  logic [1:0]    leap_r, nxt_leap;
  logic          mode24_r, halt_r, nxt_mode24, nxt_halt;

  logic [6:0]    snap_sec, snap_min;
  logic [5:0]    snap_hour, snap_day;
  logic [4:0]    snap_month;
  logic [7:0]    snap_year;
  logic [2:0]    snap_wday;
  logic [1:0]    snap_leap;
  logic          snap_mode24, snap_halt;

  logic adv, sec_inc;
  logic carry_min, carry_hour, carry_day, carry_month, carry_year;

  assign adv     = ce_tick & ~halt_r & ~wr_en;
  assign sec_inc = adv && (presc == PS_LAST);

  always_comb begin
    nxt_presc   = presc;
    nxt_sec     = sec_r;
    nxt_min     = min_r;
    nxt_hour    = hour_r;
    nxt_day     = day_r;
    nxt_month   = month_r;
    nxt_year    = year_r;
    nxt_wday    = wday_r;
    nxt_leap    = leap_r;
    nxt_mode24  = mode24_r;
    nxt_halt    = halt_r;
    carry_min   = 1'b0;
    carry_hour  = 1'b0;
    carry_day   = 1'b0;
    carry_month = 1'b0;
    carry_year  = 1'b0;

    if (wr_en && wr_sel == 3'd0) nxt_presc = '0;
    else if (adv)                nxt_presc = (presc == PS_LAST) ? '0 : presc + PW'(1);

    if (sec_inc) begin
      if (sec_r == 7'h59) begin nxt_sec = 7'h00; carry_min = 1'b1; end
      else nxt_sec = 7'(bcd_inc({1'b0, sec_r}));
    end
    if (carry_min) begin
      if (min_r == 7'h59) begin nxt_min = 7'h00; carry_hour = 1'b1; end
      else nxt_min = 7'(bcd_inc({1'b0, min_r}));
    end
    // 12 h: bit5 is PM; 11->12 flips the meridian, and only PM 11 ends the day.
    if (carry_hour) begin
      if (mode24_r) begin
        if (hour_r == 6'h23) begin nxt_hour = 6'h00; carry_day = 1'b1; end
        else nxt_hour = 6'(bcd_inc({2'b00, hour_r}));
      end else if (hour_r[4:0] == 5'h11) begin
        nxt_hour  = {~hour_r[5], 5'h12};
        carry_day = hour_r[5];
      end else if (hour_r[4:0] == 5'h12) begin
        nxt_hour = {hour_r[5], 5'h01};
      end else begin
        nxt_hour = {hour_r[5], 5'(bcd_inc({3'b000, hour_r[4:0]}))};
      end
    end
    if (carry_day) begin
      nxt_wday = HAS_WEEKDAY ? ((wday_r == 3'd6) ? 3'd0 : wday_r + 3'd1) : 3'd0;
      if (day_r == days_in_month(month_r, leap_r)) begin nxt_day = 6'h01; carry_month = 1'b1; end
      else nxt_day = 6'(bcd_inc({2'b00, day_r}));
    end
    if (carry_month) begin
      if (month_r == 5'h12) begin nxt_month = 5'h01; carry_year = 1'b1; end
      else nxt_month = 5'(bcd_inc({3'b000, month_r}));
    end
    if (carry_year) begin
      nxt_year = (year_r == 8'h99) ? 8'h00 : bcd_inc(year_r);
      nxt_leap = leap_r + 2'd1;
    end

    // A write holds the prescaler, so it never collides with a carry above.
    if (wr_en) begin
      case (wr_sel)
        3'd0: nxt_sec   = wr_data[6:0];
        3'd1: nxt_min   = wr_data[6:0];
        3'd2: nxt_hour  = wr_data[5:0];
        3'd3: nxt_day   = wr_data[5:0];
        3'd4: nxt_month = wr_data[4:0];
        3'd5: nxt_year  = wr_data;
        3'd6: nxt_wday  = HAS_WEEKDAY ? wr_data[2:0] : 3'd0;
        default: begin
          nxt_leap   = wr_data[3:2];
          nxt_mode24 = wr_data[1];
          nxt_halt   = wr_data[0];
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      presc       <= '0;
      sec_r       <= 7'h00;
      min_r       <= 7'h00;
      hour_r      <= 6'h00;
      day_r       <= 6'h01;
      month_r     <= 5'h01;
      year_r      <= 8'h00;
      wday_r      <= 3'd0;
      leap_r      <= 2'd0;
      mode24_r    <= 1'b1;
      halt_r      <= 1'b0;
      snap_sec    <= 7'h00;
      snap_min    <= 7'h00;
      snap_hour   <= 6'h00;
      snap_day    <= 6'h01;
      snap_month  <= 5'h01;
      snap_year   <= 8'h00;
      snap_wday   <= 3'd0;
      snap_leap   <= 2'd0;
      snap_mode24 <= 1'b1;
      snap_halt   <= 1'b0;
      sec_pulse   <= 1'b0;
      day_pulse   <= 1'b0;
    end else begin
      presc     <= nxt_presc;
      sec_r     <= nxt_sec;
      min_r     <= nxt_min;
      hour_r    <= nxt_hour;
      day_r     <= nxt_day;
      month_r   <= nxt_month;
      year_r    <= nxt_year;
      wday_r    <= nxt_wday;
      leap_r    <= nxt_leap;
      mode24_r  <= nxt_mode24;
      halt_r    <= nxt_halt;
      sec_pulse <= sec_inc;
      day_pulse <= carry_day;
      // Snapshot takes post-update values, so a coincident write lands in it.
      if (latch) begin
        snap_sec    <= nxt_sec;
        snap_min    <= nxt_min;
        snap_hour   <= nxt_hour;
        snap_day    <= nxt_day;
        snap_month  <= nxt_month;
        snap_year   <= nxt_year;
        snap_wday   <= nxt_wday;
        snap_leap   <= nxt_leap;
        snap_mode24 <= nxt_mode24;
        snap_halt   <= nxt_halt;
      end
    end
  end

  assign halted = halt_r;

  always_comb begin
    case (rd_sel)
      3'd0:    rd_data = {1'b0, snap_sec};
      3'd1:    rd_data = {1'b0, snap_min};
      3'd2:    rd_data = {2'b00, snap_hour};
      3'd3:    rd_data = {2'b00, snap_day};
      3'd4:    rd_data = {3'b000, snap_month};
      3'd5:    rd_data = snap_year;
      3'd6:    rd_data = {5'b00000, snap_wday};
      default: rd_data = {4'b0000, snap_leap, snap_mode24, snap_halt};
    endcase
  end

endmodule

// File: tb/tb_bcd_rtc.sv
// Bench for bcd_rtc: decimal calendar model checked every cycle against the DUT,
// directed calendar edge cases with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_bcd_rtc;
  localparam int TD = 4;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_tick = 1'b0, wr_en = 1'b0, latch = 1'b0;
  logic [2:0] wr_sel = 3'd0, rd_sel = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       sec_pulse, day_pulse, halted;

  int n_vec = 0, n_err = 0, sp_total = 0, dp_total = 0;
  bit chk_on = 1'b0;

  bcd_rtc #(.TICK_DIV(TD), .HAS_WEEKDAY(1'b1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_tick(ce_tick), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_data(wr_data), .latch(latch), .rd_sel(rd_sel),
    .rd_data(rd_data), .sec_pulse(sec_pulse), .day_pulse(day_pulse), .halted(halted)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------- behavioural model (decimal fields) ----------------
  int m_sec, m_min, m_hr, m_day, m_mon, m_year, m_wd, m_leap, m_presc;
  bit m_pm, m_m24, m_halt, m_sp, m_dp;
  logic [7:0] m_snap [8];

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int dim(input int mon, input int lp);
    if (mon == 2) return (lp == 0) ? 29 : 28;
    if (mon == 4 || mon == 6 || mon == 9 || mon == 11) return 30;
    return 31;
  endfunction

  function automatic logic [7:0] live_byte(input int sel);
    case (sel)
      0: return bcd(m_sec);
      1: return bcd(m_min);
      2: return m_m24 ? bcd(m_hr) : ({2'b00, m_pm, 5'b00000} | bcd(m_hr));
      3: return bcd(m_day);
      4: return bcd(m_mon);
      5: return bcd(m_year);
      6: return 8'(m_wd);
      default: return {4'b0000, 2'(m_leap), m_m24, m_halt};
    endcase
  endfunction

  task automatic m_reset();
    m_sec = 0; m_min = 0; m_hr = 0; m_pm = 0; m_day = 1; m_mon = 1; m_year = 0;
    m_wd = 0; m_leap = 0; m_m24 = 1; m_halt = 0; m_presc = 0; m_sp = 0; m_dp = 0;
    for (int i = 0; i < 8; i++) m_snap[i] = live_byte(i);
  endtask

  task automatic m_next_day();
    m_dp = 1;
    m_wd = (m_wd + 1) % 7;
    if (m_day == dim(m_mon, m_leap)) begin
      m_day = 1;
      if (m_mon == 12) begin
        m_mon = 1; m_year = (m_year + 1) % 100; m_leap = (m_leap + 1) % 4;
      end else m_mon = m_mon + 1;
    end else m_day = (m_day + 1) % 40;
  endtask

  task automatic m_next_second();
    m_sp = 1;
    m_sec = (m_sec + 1) % 60;
    if (m_sec != 0) return;
    m_min = (m_min + 1) % 60;
    if (m_min != 0) return;
    if (m_m24) begin
      if (m_hr == 23) begin m_hr = 0; m_next_day(); end
      else m_hr = (m_hr + 1) % 40;
    end else if (m_hr == 11) begin
      m_hr = 12;
      if (m_pm) m_next_day();
      m_pm = !m_pm;
    end else if (m_hr == 12) m_hr = 1;
    else m_hr = m_hr + 1;
  endtask

  task automatic m_set_hour(input logic [7:0] raw);
    if (m_m24) begin m_pm = 0; m_hr = from_bcd(raw & 8'h3F); end
    else begin m_pm = raw[5]; m_hr = from_bcd(raw & 8'h1F); end
  endtask

  task automatic m_write(input logic [2:0] sel, input logic [7:0] d);
    logic [7:0] raw;
    case (sel)
      3'd0: begin m_sec = from_bcd(d); m_presc = 0; end
      3'd1: m_min = from_bcd(d);
      3'd2: m_set_hour(d);
      3'd3: m_day = from_bcd(d);
      3'd4: m_mon = from_bcd(d);
      3'd5: m_year = from_bcd(d);
      3'd6: m_wd = int'(d[2:0]);
      default: begin
        // Mode change keeps the stored hour bits and reinterprets them.
        raw = live_byte(2);
        m_m24 = d[1];
        m_set_hour(raw);
        m_leap = int'(d[3:2]);
        m_halt = d[0];
      end
    endcase
  endtask

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) m_reset();
    else begin
      m_sp = 0; m_dp = 0;
      if (wr_en) m_write(wr_sel, wr_data);
      else if (ce_tick && !m_halt) begin
        if (m_presc == TD - 1) begin m_presc = 0; m_next_second(); end
        else m_presc = m_presc + 1;
      end
      if (latch) for (int i = 0; i < 8; i++) m_snap[i] = live_byte(i);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dut=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk_sys);
      if (sec_pulse) sp_total++;
      if (day_pulse) dp_total++;
      if (chk_on) begin
        chk("rd_data", rd_data, m_snap[rd_sel]);
        chk("sec_pulse", {7'b0, sec_pulse}, {7'b0, m_sp});
        chk("day_pulse", {7'b0, day_pulse}, {7'b0, m_dp});
        chk("halted", {7'b0, halted}, {7'b0, m_halt});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic t, input logic w, input logic [2:0] ws,
                     input logic [7:0] wd, input logic l);
    @(posedge clk_sys); #1;
    ce_tick = t; wr_en = w; wr_sel = ws; wr_data = wd; latch = l;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] d);
    cyc(1'b0, 1'b1, sel, d, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic read_field(input logic [2:0] sel, input logic [7:0] exp, input string name);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    rd_sel = sel;
    @(negedge clk_sys);
    chk({name, "/dut"}, rd_data, exp);
    chk({name, "/model"}, m_snap[sel], exp);
  endtask

  task automatic do_reset();
    @(posedge clk_sys); #3;
    reset_n = 1'b0; ce_tick = 1'b0; wr_en = 1'b0; latch = 1'b0;
    @(posedge clk_sys); @(posedge clk_sys); #1;
    reset_n = 1'b1;
  endtask

  task automatic set_time(input logic [7:0] ctl, input logic [7:0] hr, input logic [7:0] dy,
                          input logic [7:0] mo);
    wr(3'd7, ctl); wr(3'd3, dy); wr(3'd4, mo);
    wr(3'd2, hr); wr(3'd1, 8'h59); wr(3'd0, 8'h59);
  endtask

  function automatic logic [7:0] rand_val(input logic [2:0] sel, input bit m24);
    case (sel)
      3'd0, 3'd1: return bcd(int'($urandom_range(0, 59)));
      3'd2: return m24 ? bcd(int'($urandom_range(0, 23)))
                       : ({2'b00, 1'($urandom_range(0, 1)), 5'b00000} | bcd(int'($urandom_range(1, 12))));
      3'd3: return bcd(int'($urandom_range(1, 31)));
      3'd4: return bcd(int'($urandom_range(1, 12)));
      3'd5: return bcd(int'($urandom_range(0, 99)));
      3'd6: return 8'($urandom_range(0, 6));
      default: return {4'b0000, 2'($urandom_range(0, 3)), m24, ($urandom_range(0, 3) == 0)};
    endcase
  endfunction

  task automatic rand_phase(input int n, input bit m24);
    logic [2:0] ws;
    wr(3'd7, m24 ? 8'h02 : 8'h00);
    wr(3'd2, m24 ? 8'h23 : 8'h31); wr(3'd1, 8'h59); wr(3'd0, 8'h50);
    wr(3'd3, 8'h28); wr(3'd4, 8'h02);
    for (int i = 0; i < n; i++) begin
      ws = 3'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ws, rand_val(ws, m24),
          ($urandom_range(0, 7) == 0));
      rd_sel = 3'($urandom_range(0, 7));
    end
    wr(3'd7, m24 ? 8'h02 : 8'h00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sp0, dp0;
    fork compare_loop(); join_none

    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    chk_on = 1'b1;

    // Reset state
    @(negedge clk_sys);
    chk("rst_rd_sec", rd_data, 8'h00);
    read_field(3'd7, 8'h02, "rst_ctrl");
    read_field(3'd3, 8'h01, "rst_day");
    read_field(3'd4, 8'h01, "rst_month");

    // One second after TD ticks, one minute after 60*TD
    do_reset();
    sp0 = sp_total;
    ticks(4);
    read_field(3'd0, 8'h01, "t1_sec");
    chk("t1_sec_pulses", 8'(sp_total - sp0), 8'd1);
    do_reset();
    ticks(240);
    read_field(3'd1, 8'h01, "t1_min");
    read_field(3'd0, 8'h00, "t1_sec0");

    // Feb 28 with leap phase 1 rolls to Mar 1
    set_time(8'h06, 8'h23, 8'h28, 8'h02);
    dp0 = dp_total;
    ticks(4);
    read_field(3'd2, 8'h00, "t2_hour");
    read_field(3'd3, 8'h01, "t2_day");
    read_field(3'd4, 8'h03, "t2_month");
    chk("t2_day_pulses", 8'(dp_total - dp0), 8'd1);
    // Leap phase 0: Feb has a 29th
    set_time(8'h02, 8'h23, 8'h28, 8'h02);
    ticks(4);
    read_field(3'd3, 8'h29, "t2l_day");
    read_field(3'd4, 8'h02, "t2l_month");

    // 12 h mode meridian handling
    set_time(8'h00, 8'h11, 8'h10, 8'h05);
    dp0 = dp_total;
    ticks(4);
    read_field(3'd2, 8'h32, "t3_am11");
    read_field(3'd3, 8'h10, "t3_day_same");
    chk("t3_no_day_pulse", 8'(dp_total - dp0), 8'd0);
    wr(3'd2, 8'h31); wr(3'd1, 8'h59); wr(3'd0, 8'h59);
    ticks(4);
    read_field(3'd2, 8'h12, "t3_pm11");
    read_field(3'd3, 8'h11, "t3_day_inc");

    // New year
    set_time(8'h0E, 8'h23, 8'h31, 8'h12);
    wr(3'd5, 8'h99); wr(3'd6, 8'h06);
    ticks(4);
    read_field(3'd3, 8'h01, "t4_day");
    read_field(3'd4, 8'h01, "t4_month");
    read_field(3'd5, 8'h00, "t4_year");
    read_field(3'd6, 8'h00, "t4_wday");
    read_field(3'd7, 8'h02, "t4_ctrl");

    // Write on the terminal tick defers the increment
    wr(3'd0, 8'h00);
    sp0 = sp_total;
    repeat (3) cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 3'd5, 8'h42, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    read_field(3'd0, 8'h00, "t5_deferred");
    chk("t5_no_pulse", 8'(sp_total - sp0), 8'd0);
    ticks(1);
    read_field(3'd0, 8'h01, "t5_after");
    read_field(3'd5, 8'h42, "t5_year_wr");
    // Latch coincident with a write captures the written value
    cyc(1'b0, 1'b1, 3'd5, 8'h77, 1'b1);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    rd_sel = 3'd5;
    @(negedge clk_sys);
    chk("t5_wr_latch", rd_data, 8'h77);
    // Halt freezes everything
    wr(3'd7, 8'h03);
    sp0 = sp_total;
    ticks(100);
    read_field(3'd0, 8'h01, "t5_halt_sec");
    read_field(3'd7, 8'h03, "t5_halt_ctrl");
    chk("t5_halt_pulses", 8'(sp_total - sp0), 8'd0);
    wr(3'd7, 8'h02);

    // Snapshot holds while live seconds advance
    wr(3'd0, 8'h20);
    read_field(3'd0, 8'h20, "t6_latched");
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk_sys);
      chk("t6_hold", rd_data, 8'h20);
    end
    read_field(3'd0, 8'h22, "t6_relatch");

    // Async reset during a sec_pulse cycle
    wr(3'd0, 8'h00);
    wr(3'd7, 8'h03);
    wr(3'd7, 8'h02);
    repeat (4) cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    @(posedge clk_sys); #3;
    chk("t6_pulse_before_rst", {7'b0, sec_pulse}, 8'h01);
    reset_n = 1'b0; ce_tick = 1'b0;
    #1;
    chk("t6_rst_sec_pulse", {7'b0, sec_pulse}, 8'h00);
    chk("t6_rst_day_pulse", {7'b0, day_pulse}, 8'h00);
    chk("t6_rst_halted", {7'b0, halted}, 8'h00);
    chk("t6_rst_rd_sec", rd_data, 8'h00);
    rd_sel = 3'd7; #1;
    chk("t6_rst_rd_ctrl", rd_data, 8'h02);
    rd_sel = 3'd4; #1;
    chk("t6_rst_rd_month", rd_data, 8'h01);
    @(posedge clk_sys); #1 reset_n = 1'b1;
    sp0 = sp_total;
    ticks(4);
    read_field(3'd0, 8'h01, "t6_restart");
    chk("t6_restart_pulses", 8'(sp_total - sp0), 8'd1);

    // Randomised traffic in both hour modes
    rand_phase(2500, 1'b1);
    rand_phase(2500, 1'b0);

    ticks(2);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
